// File: rtl/fifo_rr_write_arbiter_if.sv
// Bundle between N_REQ producers, one consumer and the shared round-robin write FIFO.
// Handshake: req[i] acts as valid with din slice i held stable; gnt[i] is the same-cycle
// accept, so the slice is stored on the edge where req[i] & gnt[i]. rd pops only when ~empty.
interface fifo_rr_write_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [N_REQ-1:0]            req;
    logic [N_REQ*DATA_WIDTH-1:0] din;
    logic [N_REQ-1:0]            gnt;
    logic                        rd;
    logic [DATA_WIDTH-1:0]       dout;
    logic                        empty;
    logic                        full;
    logic [CW-1:0]               count;

    modport master (
        output req, din, rd,
        input  gnt, dout, empty, full, count
    );

    modport slave (
        input  req, din, rd,
        output gnt, dout, empty, full, count
    );
endinterface

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin arbiter granting one of N_REQ writers per cycle into a shared FIFO,
// drained by a single consumer. Status flags derive from count only.
module fifo_rr_write_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input logic                    clk,
    input logic                    resetn,
    fifo_rr_write_arbiter_if.slave bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] entries [DEPTH];
    logic [AW-1:0]         head;
    logic [AW-1:0]         tail;
    logic [CW-1:0]         count;
    logic [PW-1:0]         prio;

    logic                  empty;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  space;
    logic [N_REQ-1:0]      gnt;
    logic [PW-1:0]         gnt_idx;
    logic [DATA_WIDTH-1:0] din_sel;
    logic [PW-1:0]         sel;
    logic                  found;
    int                    idx;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign pop   = bus.rd & ~empty;
    // A full FIFO being popped this cycle still has room for one write.
    assign space = ~full | pop;
    assign push  = |gnt;

    // Scan requesters starting at prio, wrapping modulo N_REQ; first set req wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = prio;
        din_sel = '0;
        found   = 1'b0;
        idx     = 0;
        sel     = '0;
        if (resetn && space) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = int'(prio) + k;
                if (idx >= N_REQ) idx = idx - N_REQ;
                sel = PW'(idx);
                if (!found && bus.req[sel]) begin
                    found        = 1'b1;
                    gnt[sel]     = 1'b1;
                    gnt_idx      = sel;
                    din_sel      = bus.din[sel*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            prio  <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else begin
            if (push) begin
                entries[tail] <= din_sel;
                tail          <= tail + 1'b1;
                prio          <= (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.gnt   = gnt;
    assign bus.dout  = empty ? '0 : entries[head];
    assign bus.empty = empty;
    assign bus.full  = full;
    assign bus.count = count;
endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Bench for fifo_rr_write_arbiter: directed vector table, pointer-wrap sequence and
// randomized traffic checked against a queue-based reference model.
module tb_fifo_rr_write_arbiter;
    localparam int N_REQ = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [N_REQ*DW-1:0] DA = 32'hA3A2A1A0;
    localparam logic [N_REQ*DW-1:0] DB = 32'h0000B1B0;
    localparam logic [N_REQ*DW-1:0] DC = 32'hC300B1B0;

    typedef struct {
        logic             rst_n;
        logic [N_REQ-1:0] req;
        logic [N_REQ*DW-1:0] din;
        logic             rd;
        logic [N_REQ-1:0] gnt;
        logic [CW-1:0]    count;
        logic [DW-1:0]    dout;
        logic             empty;
        logic             full;
    } vec_t;

    // clock / reset
    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    fifo_rr_write_arbiter_if #(.N_REQ(N_REQ), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    fifo_rr_write_arbiter #(.N_REQ(N_REQ), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // scoreboard / reference model state
    logic [DW-1:0] exp_q[$];
    int            m_prio = 0;

    vec_t vecs[27];

    function automatic vec_t mk(input logic r, input logic [N_REQ-1:0] rq,
                                input logic [N_REQ*DW-1:0] d, input logic rd_i,
                                input logic [N_REQ-1:0] g, input logic [CW-1:0] c,
                                input logic [DW-1:0] dq, input logic e, input logic f);
        vec_t v;
        v.rst_n = r; v.req = rq; v.din = d; v.rd = rd_i;
        v.gnt = g; v.count = c; v.dout = dq; v.empty = e; v.full = f;
        return v;
    endfunction

    // driver: inputs change just after the active edge, outputs sampled at negedge
    task automatic drive(input logic r, input logic [N_REQ-1:0] rq,
                         input logic [N_REQ*DW-1:0] d, input logic rd_i);
        @(posedge clk);
        #1;
        resetn  = r;
        bus.req = rq;
        bus.din = d;
        bus.rd  = rd_i;
        @(negedge clk);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int idx,
                              input logic [N_REQ-1:0] g, input logic [CW-1:0] c,
                              input logic [DW-1:0] dq, input logic e, input logic f);
        check({tag, ".gnt"},   idx, 32'(bus.gnt),   32'(g));
        check({tag, ".count"}, idx, 32'(bus.count), 32'(c));
        check({tag, ".dout"},  idx, 32'(bus.dout),  32'(dq));
        check({tag, ".empty"}, idx, 32'(bus.empty), 32'(e));
        check({tag, ".full"},  idx, 32'(bus.full),  32'(f));
    endtask

    initial begin
        logic [DW-1:0]       v8;
        logic                r;
        logic [N_REQ-1:0]    rq;
        logic [N_REQ*DW-1:0] d;
        logic                rd_i;
        logic [N_REQ-1:0]    e_gnt;
        logic [DW-1:0]       e_dout;
        int                  g;
        int                  rd_pct;

        bus.req = '0;
        bus.din = '0;
        bus.rd  = 1'b0;
        resetn  = 1'b0;
        repeat (2) @(posedge clk);

        // directed vectors: expected outputs are those seen before the edge consuming the row
        vecs[0]  = mk(0, 4'hF, DA, 0, 4'h0, 3'd0, 8'h00, 1, 0);
        vecs[1]  = mk(1, 4'hF, DA, 0, 4'h1, 3'd0, 8'h00, 1, 0);
        vecs[2]  = mk(1, 4'hF, DA, 0, 4'h2, 3'd1, 8'hA0, 0, 0);
        vecs[3]  = mk(1, 4'hF, DA, 0, 4'h4, 3'd2, 8'hA0, 0, 0);
        vecs[4]  = mk(1, 4'hF, DA, 0, 4'h8, 3'd3, 8'hA0, 0, 0);
        vecs[5]  = mk(1, 4'hF, DA, 0, 4'h0, 3'd4, 8'hA0, 0, 1);
        vecs[6]  = mk(1, 4'h0, '0, 1, 4'h0, 3'd4, 8'hA0, 0, 1);
        vecs[7]  = mk(1, 4'h0, '0, 1, 4'h0, 3'd3, 8'hA1, 0, 0);
        vecs[8]  = mk(1, 4'h0, '0, 1, 4'h0, 3'd2, 8'hA2, 0, 0);
        vecs[9]  = mk(1, 4'h0, '0, 1, 4'h0, 3'd1, 8'hA3, 0, 0);
        vecs[10] = mk(1, 4'h0, '0, 0, 4'h0, 3'd0, 8'h00, 1, 0);
        vecs[11] = mk(1, 4'h0, '0, 1, 4'h0, 3'd0, 8'h00, 1, 0);
        vecs[12] = mk(1, 4'h3, DB, 0, 4'h1, 3'd0, 8'h00, 1, 0);
        vecs[13] = mk(1, 4'h2, DB, 0, 4'h2, 3'd1, 8'hB0, 0, 0);
        vecs[14] = mk(1, 4'h3, DB, 0, 4'h1, 3'd2, 8'hB0, 0, 0);
        vecs[15] = mk(1, 4'h3, DB, 0, 4'h2, 3'd3, 8'hB0, 0, 0);
        vecs[16] = mk(1, 4'h8, DC, 0, 4'h0, 3'd4, 8'hB0, 0, 1);
        vecs[17] = mk(1, 4'h1, DC, 1, 4'h1, 3'd4, 8'hB0, 0, 1);
        vecs[18] = mk(1, 4'h0, '0, 1, 4'h0, 3'd4, 8'hB1, 0, 1);
        vecs[19] = mk(1, 4'h0, '0, 1, 4'h0, 3'd3, 8'hB0, 0, 0);
        vecs[20] = mk(1, 4'h0, '0, 1, 4'h0, 3'd2, 8'hB1, 0, 0);
        vecs[21] = mk(1, 4'h0, '0, 1, 4'h0, 3'd1, 8'hB0, 0, 0);
        vecs[22] = mk(1, 4'h0, '0, 0, 4'h0, 3'd0, 8'h00, 1, 0);
        vecs[23] = mk(1, 4'h1, DB, 0, 4'h1, 3'd0, 8'h00, 1, 0);
        vecs[24] = mk(0, 4'h1, DB, 0, 4'h0, 3'd1, 8'hB0, 0, 0);
        vecs[25] = mk(1, 4'h0, '0, 0, 4'h0, 3'd0, 8'h00, 1, 0);
        vecs[26] = mk(1, 4'h3, DB, 0, 4'h1, 3'd0, 8'h00, 1, 0);

        for (int i = 0; i < 27; i++) begin
            drive(vecs[i].rst_n, vecs[i].req, vecs[i].din, vecs[i].rd);
            check_outs("vec", i, vecs[i].gnt, vecs[i].count, vecs[i].dout,
                       vecs[i].empty, vecs[i].full);
        end

        // push/pop pairs across the pointer wrap
        drive(0, '0, '0, 0);
        for (int i = 0; i < 6; i++) begin
            v8 = 8'(8'h11 + i);
            drive(1, 4'h1, {24'h0, v8}, 0);
            check_outs("wrap_push", i, 4'h1, 3'd0, 8'h00, 1, 0);
            drive(1, 4'h0, '0, 1);
            check_outs("wrap_pop", i, 4'h0, 3'd1, v8, 0, 0);
        end
        drive(1, 4'h0, '0, 0);
        check_outs("wrap_end", 0, 4'h0, 3'd0, 8'h00, 1, 0);

        // randomized traffic against the queue model
        drive(0, '0, '0, 0);
        exp_q.delete();
        m_prio = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            rd_pct = ((cyc / 100) % 2 == 0) ? 20 : 70;
            r    = ($urandom_range(0, 60) != 0);
            rq   = N_REQ'($urandom_range(0, 15));
            d    = $urandom();
            rd_i = ($urandom_range(0, 99) < rd_pct);
            drive(r, rq, d, rd_i);

            e_gnt = '0;
            g     = -1;
            if (r && (exp_q.size() < DEPTH || (rd_i && exp_q.size() > 0))) begin
                for (int k = 0; k < N_REQ; k++) begin
                    if (g < 0 && rq[(m_prio + k) % N_REQ]) g = (m_prio + k) % N_REQ;
                end
                if (g >= 0) e_gnt[g] = 1'b1;
            end
            e_dout = (exp_q.size() > 0) ? exp_q[0] : '0;
            check_outs("rand", cyc, e_gnt, CW'(exp_q.size()), e_dout,
                       exp_q.size() == 0, exp_q.size() == DEPTH);

            if (!r) begin
                exp_q.delete();
                m_prio = 0;
            end else begin
                if (rd_i && exp_q.size() > 0) void'(exp_q.pop_front());
                if (g >= 0) begin
                    exp_q.push_back(d[g*DW +: DW]);
                    m_prio = (g + 1) % N_REQ;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
